// File: rtl/calc_sequencer_if.sv
// Bus between the calculator sequencer, its keypad and its ALU.
// The slave modport is the sequencer's view; master is the keypad/ALU side.
interface calc_sequencer_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] regA;
  logic [7:0] regB;
  logic [1:0] opcode;
  logic       computestrobe;
  logic [7:0] result;
  logic       ovf;
  logic [7:0] display;
  logic       error;
  logic       busy;

  modport slave (
    input  key_valid, key_code, result, ovf,
    output regA, regB, opcode, computestrobe, display, error, busy
  );

  modport master (
    output key_valid, key_code, result, ovf,
    input  regA, regB, opcode, computestrobe, display, error, busy
  );
endinterface

// File: rtl/calc_sequencer.sv
// Keypad-driven calculator sequencer: builds two 8-bit operands, fires the ALU, shows the result.
// Define CALC_SEQUENCER_CHAIN_EN to let an operator in SHOW chain from the displayed result.
module calc_sequencer (
  input logic             clock,
  input logic             reset_n,
  calc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    ENTER_A,
    ENTER_B,
    COMPUTE,
    WAIT,
    SHOW,
    ERR
  } state_t;

  state_t      state, state_next;
  logic [7:0]  reg_a, reg_a_next;
  logic [7:0]  reg_b, reg_b_next;
  logic [1:0]  opcode, opcode_next;
  logic [7:0]  display, display_next;
  logic        error, error_next;

  logic        is_digit, is_op, is_equals, is_clear, busy;
  logic [1:0]  key_op;
  logic [7:0]  active;
  logic [11:0] entry_value;
  logic        entry_ovf;

  assign is_digit  = bus.key_valid && (bus.key_code <= 4'd9);
  assign is_op     = bus.key_valid && (bus.key_code >= 4'd10) && (bus.key_code <= 4'd13);
  assign is_equals = bus.key_valid && (bus.key_code == 4'd14);
  assign is_clear  = bus.key_valid && (bus.key_code == 4'd15);
  // key_code-10 for codes 10..13 reduces to the low two bits plus 2 (mod 4)
  assign key_op    = bus.key_code[1:0] + 2'd2;

  assign busy        = (state == COMPUTE) || (state == WAIT);
  assign active      = (state == ENTER_B) ? reg_b : reg_a;
  assign entry_value = 12'(active) * 12'd10 + 12'(bus.key_code);
  assign entry_ovf   = (entry_value > 12'd255);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= ENTER_A;
      reg_a   <= 8'd0;
      reg_b   <= 8'd0;
      opcode  <= 2'b00;
      display <= 8'd0;
      error   <= 1'b0;
    end else begin
      state   <= state_next;
      reg_a   <= reg_a_next;
      reg_b   <= reg_b_next;
      opcode  <= opcode_next;
      display <= display_next;
      error   <= error_next;
    end
  end

  always_comb begin
    state_next   = state;
    reg_a_next   = reg_a;
    reg_b_next   = reg_b;
    opcode_next  = opcode;
    display_next = display;
    error_next   = error;

    case (state)
      ENTER_A, ENTER_B: begin
        if (is_digit) begin
          if (entry_ovf) begin
            state_next = ERR;
            error_next = 1'b1;
          end else begin
            if (state == ENTER_A) reg_a_next = entry_value[7:0];
            else                  reg_b_next = entry_value[7:0];
            display_next = entry_value[7:0];
          end
        end else if (is_op) begin
          opcode_next = key_op;
          if (state == ENTER_A) begin
            reg_b_next = 8'd0;
            state_next = ENTER_B;
          end
        end else if (is_equals && (state == ENTER_B)) begin
          // Divide by zero is caught here so the ALU never sees it
          if ((opcode == 2'b11) && (reg_b == 8'd0)) begin
            state_next = ERR;
            error_next = 1'b1;
          end else begin
            state_next = COMPUTE;
          end
        end
      end
      COMPUTE: state_next = WAIT;
      WAIT: begin
        if (bus.ovf) begin
          state_next = ERR;
          error_next = 1'b1;
        end else begin
          display_next = bus.result;
          state_next   = SHOW;
        end
      end
      SHOW: begin
        if (is_digit) begin
          reg_a_next   = {4'd0, bus.key_code};
          display_next = {4'd0, bus.key_code};
          state_next   = ENTER_A;
        end else if (is_op) begin
`ifdef CALC_SEQUENCER_CHAIN_EN
          reg_a_next  = display;
          opcode_next = key_op;
          reg_b_next  = 8'd0;
          state_next  = ENTER_B;
`else
          state_next  = SHOW;
`endif
        end
      end
      ERR:     state_next = ERR;
      default: state_next = ENTER_A;
    endcase

    // Clear wins in every state that is not waiting on the ALU
    if (is_clear && !busy) begin
      state_next   = ENTER_A;
      reg_a_next   = 8'd0;
      reg_b_next   = 8'd0;
      opcode_next  = 2'b00;
      display_next = 8'd0;
      error_next   = 1'b0;
    end
  end

  assign bus.regA          = reg_a;
  assign bus.regB          = reg_b;
  assign bus.opcode        = opcode;
  assign bus.computestrobe = (state == COMPUTE);
  assign bus.display       = display;
  assign bus.error         = error;
  assign bus.busy          = busy;

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer: directed key sequences, with a scoreboard monitor checking
// each ALU request and the value it leaves on the display.
module tb_calc_sequencer;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] disp;
    logic       err;
  } exp_t;

  localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_MUL = 4'd12, K_DIV = 4'd13;
  localparam logic [3:0] K_EQ  = 4'd14, K_CLR = 4'd15;

  logic clock;
  logic reset_n;
  int   tests;
  int   failed;
  exp_t exp_q[$];

  calc_sequencer_if bus ();

  calc_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One-cycle key pulse, sampled on the next rising edge; returns 1 time unit after that edge
  task automatic applyStimulus(input logic [3:0] code);
    @(posedge clock);
    #1;
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(posedge clock);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  // Monitor: every ALU request must match the oldest expectation, hold for one cycle in WAIT,
  // then leave the expected display/error once the sequencer is no longer busy.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.computestrobe === 1'b1) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("strobe_regA",   int'(bus.regA),   int'(e.a));
          checkOutput("strobe_regB",   int'(bus.regB),   int'(e.b));
          checkOutput("strobe_opcode", int'(bus.opcode), int'(e.op));
          checkOutput("strobe_busy",   int'(bus.busy),   1);
          @(negedge clock);
          checkOutput("wait_strobe_low", int'(bus.computestrobe), 0);
          checkOutput("wait_busy",       int'(bus.busy),   1);
          checkOutput("wait_regA",       int'(bus.regA),   int'(e.a));
          checkOutput("wait_regB",       int'(bus.regB),   int'(e.b));
          checkOutput("wait_opcode",     int'(bus.opcode), int'(e.op));
          @(negedge clock);
          checkOutput("after_busy",    int'(bus.busy),    0);
          checkOutput("after_display", int'(bus.display), int'(e.disp));
          checkOutput("after_error",   int'(bus.error),   int'(e.err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests          = 0;
    failed         = 0;
    reset_n        = 1'b0;
    bus.key_valid  = 1'b0;
    bus.key_code   = 4'd0;
    bus.result     = 8'd0;
    bus.ovf        = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    checkOutput("reset_regA",    int'(bus.regA),          0);
    checkOutput("reset_regB",    int'(bus.regB),          0);
    checkOutput("reset_opcode",  int'(bus.opcode),        0);
    checkOutput("reset_display", int'(bus.display),       0);
    checkOutput("reset_error",   int'(bus.error),         0);
    checkOutput("reset_busy",    int'(bus.busy),          0);
    checkOutput("reset_strobe",  int'(bus.computestrobe), 0);

    // Equals with no operator pending does nothing
    applyStimulus(4'd4);
    applyStimulus(K_EQ);
    idle(3);
    checkOutput("eq_in_a_busy",    int'(bus.busy),    0);
    checkOutput("eq_in_a_display", int'(bus.display), 4);
    applyStimulus(K_CLR);

    // 12 + 3 = 15
    bus.result = 8'd15;
    bus.ovf    = 1'b0;
    applyStimulus(4'd1);
    applyStimulus(4'd2);
    @(negedge clock);
    checkOutput("entry_display_12", int'(bus.display), 12);
    applyStimulus(K_ADD);
    applyStimulus(4'd3);
    @(negedge clock);
    checkOutput("entry_regB_3", int'(bus.regB), 3);
    exp_q.push_back('{a: 8'd12, b: 8'd3, op: 2'b00, disp: 8'd15, err: 1'b0});
    applyStimulus(K_EQ);
    idle(4);

    // Operator while showing 15: chains from the result only when enabled
    bus.result = 8'd10;
`ifdef CALC_SEQUENCER_CHAIN_EN
    applyStimulus(K_SUB);
    applyStimulus(4'd5);
    exp_q.push_back('{a: 8'd15, b: 8'd5, op: 2'b01, disp: 8'd10, err: 1'b0});
    applyStimulus(K_EQ);
    idle(4);
    checkOutput("chain_display", int'(bus.display), 10);
`else
    applyStimulus(K_SUB);
    @(negedge clock);
    checkOutput("show_op_ignored_display", int'(bus.display), 15);
    applyStimulus(4'd5);
    applyStimulus(K_EQ);
    idle(4);
    checkOutput("show_digit_regA",    int'(bus.regA),    5);
    checkOutput("show_digit_display", int'(bus.display), 5);
    checkOutput("show_op_no_strobe",  int'(bus.busy),    0);
`endif
    applyStimulus(K_CLR);

    // 255 is the largest operand; one more digit errors and keeps the operand
    applyStimulus(4'd2);
    applyStimulus(4'd5);
    applyStimulus(4'd5);
    @(negedge clock);
    checkOutput("max_display_255", int'(bus.display), 255);
    checkOutput("max_error_0",     int'(bus.error),   0);
    applyStimulus(4'd6);
    @(negedge clock);
    checkOutput("ovf_entry_error", int'(bus.error), 1);
    checkOutput("ovf_entry_regA",  int'(bus.regA),  255);
    applyStimulus(4'd3);
    applyStimulus(K_ADD);
    @(negedge clock);
    checkOutput("err_ignores_keys_regA",  int'(bus.regA),   255);
    checkOutput("err_ignores_keys_error", int'(bus.error),  1);
    applyStimulus(K_CLR);
    @(negedge clock);
    checkOutput("clear_display", int'(bus.display), 0);
    checkOutput("clear_error",   int'(bus.error),   0);
    checkOutput("clear_regA",    int'(bus.regA),    0);

    // 9 / 0 is rejected before the ALU is asked
    applyStimulus(4'd9);
    applyStimulus(K_DIV);
    applyStimulus(4'd0);
    applyStimulus(K_EQ);
    idle(3);
    checkOutput("div0_error",  int'(bus.error),  1);
    checkOutput("div0_opcode", int'(bus.opcode), 3);
    checkOutput("div0_busy",   int'(bus.busy),   0);
    applyStimulus(K_CLR);

    // ALU overflow: error set, display still shows operand B
    bus.result = 8'd99;
    bus.ovf    = 1'b1;
    applyStimulus(4'd7);
    applyStimulus(K_MUL);
    applyStimulus(4'd8);
    exp_q.push_back('{a: 8'd7, b: 8'd8, op: 2'b10, disp: 8'd8, err: 1'b1});
    applyStimulus(K_EQ);
    idle(4);
    applyStimulus(K_CLR);

    // Operator replacement, then a clear held through COMPUTE and WAIT must be ignored
    bus.result = 8'd3;
    bus.ovf    = 1'b0;
    applyStimulus(4'd4);
    applyStimulus(K_ADD);
    applyStimulus(4'd1);
    applyStimulus(K_SUB);
    @(negedge clock);
    checkOutput("op_replace_regB", int'(bus.regB), 1);
    exp_q.push_back('{a: 8'd4, b: 8'd1, op: 2'b01, disp: 8'd3, err: 1'b0});
    applyStimulus(K_EQ);
    bus.key_valid = 1'b1;
    bus.key_code  = K_CLR;
    @(posedge clock);
    @(posedge clock);
    #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;
    idle(3);
    applyStimulus(K_CLR);

    // Reset in WAIT aborts without capturing the result
    bus.result = 8'd8;
    applyStimulus(4'd6);
    applyStimulus(K_ADD);
    applyStimulus(4'd2);
    exp_q.push_back('{a: 8'd6, b: 8'd2, op: 2'b00, disp: 8'd0, err: 1'b0});
    applyStimulus(K_EQ);
    @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    checkOutput("reset_wait_regA",   int'(bus.regA),   0);
    checkOutput("reset_wait_opcode", int'(bus.opcode), 0);
    idle(4);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
